// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial add/sub slice.
// State encoding and mode constants.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_add_sub_cell.sv
// One-bit full adder / full subtractor slice.
// a, b, cin, m (0 add, 1 sub) -> s, cout (carry or borrow).
module full_add_sub_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic m,
  output logic s,
  output logic cout
);

  logic w_x;

  assign w_x = a ^ b;
  assign s   = w_x ^ cin;

  assign cout = (m == MODE_SUB)
              ? ((~a & b) | (cin & ~w_x))
              : (( a & b) | (cin &  w_x));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, start/busy/done.
// Ports: clk, rst_n, start, m, a, b -> busy, done, result, cout
// (+ ovf when ADDSUB_OVF_EN is defined).
module serial_add_sub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_m;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start &&
    (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last = (r_state == ST_RUN) &&
    (r_cnt == LAST);

  full_add_sub_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .m    (r_m),
    .s    (w_s),
    .cout (w_c)
  );

  // New sum bit enters at the MSB; after WIDTH
  // shifts the LSB has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_acc_nxt = w_s;
    end else begin : g_wn
      assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_nxt = ST_DONE;
      ST_DONE: w_nxt = start ? ST_RUN : ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_m     <= MODE_ADD;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_m     <= m;
        r_carry <= 1'b0;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_c;
        r_cnt   <= r_cnt + CW'(1);
        r_acc   <= w_acc_nxt;
      end
      if (w_last) begin
        result <= w_acc_nxt;
        cout   <= w_c;
`ifdef ADDSUB_OVF_EN
        // r_carry is the carry/borrow into the MSB here.
        ovf    <= r_carry ^ w_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=8 and WIDTH=1).
// Vector table plus scoreboard; corner sequences by hand.
module tb_serial_add_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic m;
    logic r;
    logic co;
  } svec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       m;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       s_start;
  logic       s_m;
  logic [0:0] s_a;
  logic [0:0] s_b;
  logic       s_busy;
  logic       s_done;
  logic [0:0] s_res;
  logic       s_cout;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
  logic       s_ovf;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sbq[$];
  vec_t mon_e;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .m      (m),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  serial_add_sub #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (s_start),
    .m      (s_m),
    .a      (s_a),
    .b      (s_b),
    .busy   (s_busy),
    .done   (s_done),
    .result (s_res),
    .cout   (s_cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf    (s_ovf)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] va,
                              input logic [7:0] vb,
                              input logic vm);
    vec_t v;
    logic [8:0] t;
    v.a = va;
    v.b = vb;
    v.m = vm;
    if (!vm) t = {1'b0, va} + {1'b0, vb};
    else     t = {1'b0, va} - {1'b0, vb};
    v.r  = t[7:0];
    v.co = t[8];
    if (!vm) v.ov = (va[7] == vb[7]) && (v.r[7] != va[7]);
    else     v.ov = (va[7] != vb[7]) && (v.r[7] != va[7]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_without_busy", {31'd0, busy}, 32'd0);
      chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("result", {24'd0, result}, {24'd0, mon_e.r});
        chk("cout", {31'd0, cout}, {31'd0, mon_e.co});
`ifdef ADDSUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ov});
`endif
      end
    end
  end

  // Called on the first falling edge after the start edge.
  task automatic wait_done(output int cyc, output int bc);
    cyc = 1;
    bc  = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_op(input vec_t v);
    int cyc, bc;
    @(negedge clk);
    a = v.a; b = v.b; m = v.m; start = 1'b1;
    sbq.push_back(v);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    chk("latency", cyc, 32'd9);
    chk("busy_cycles", bc, 32'd8);
  endtask

  vec_t  tbl[12];
  svec_t stbl[4];

  initial begin
    int cyc, bc;
    tbl[0]  = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0};
    tbl[4]  = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[5]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[8]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[9]  = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[10] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1};
    tbl[11] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    stbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    stbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    stbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    stbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; m = 1'b0;
    a = '0; b = '0;
    s_start = 1'b0; s_m = 1'b0; s_a = '0; s_b = '0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_op(tbl[i]);
    for (int i = 0; i < 8; i++)
      do_op(mk(8'($urandom), 8'($urandom), 1'($urandom)));

    // start held through RUN with changing operands
    @(negedge clk);
    a = 8'h12; b = 8'h34; m = 1'b0; start = 1'b1;
    sbq.push_back(mk(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    repeat (6) begin
      a = 8'($urandom); b = 8'($urandom); m = ~m;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(cyc, bc);
    chk("hold_result_kept", {24'd0, result}, 32'h46);

    // back-to-back: start in DONE cycle
    @(negedge clk);
    a = 8'h20; b = 8'h03; m = 1'b1; start = 1'b1;
    sbq.push_back(mk(8'h20, 8'h03, 1'b1));
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    a = 8'h90; b = 8'h90; m = 1'b0; start = 1'b1;
    sbq.push_back(mk(8'h90, 8'h90, 1'b0));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc, bc);
    chk("b2b_latency", cyc, 32'd9);

    // reset during RUN bit 3
    @(negedge clk);
    a = 8'h3C; b = 8'h05; m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", {24'd0, result}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) bc++;
    end
    chk("no_done_after_abort", bc, 32'd0);
    do_op(mk(8'h10, 8'h20, 1'b0));
    chk("post_rst_result", {24'd0, result}, 32'h30);

    // WIDTH=1 instance
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_a = stbl[i].a; s_b = stbl[i].b;
      s_m = stbl[i].m; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      cyc = 1;
      while (!s_done && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("w1_latency", cyc, 32'd2);
      chk("w1_result", {31'd0, s_res}, {31'd0, stbl[i].r});
      chk("w1_cout", {31'd0, s_cout}, {31'd0, stbl[i].co});
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
